exe_muldiv_unit: RTL and testbench

Iterative multiply/divide unit on the EX side of the pipeline, consuming the operand values, opcode-derived op select and start request that the ID/EX stage register delivers. It runs a 32-iteration shift-add multiply or restoring divide, holds the front of the pipeline with `stall` while busy, and writes the 64-bit result into architectural HI/LO registers. Following MUL/DIV instructions see HI/LO updated from the `done` cycle onward.

---
 rtl/exe_muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : exe_muldiv_unit
// Purpose  : Iterative 32-step multiply / divide unit on the EX side. Runs a
//            shift-add multiply or restoring divide, holds the front of the
//            pipeline with stall while busy, and writes the 64-bit result into
//            the architectural HI/LO registers on the done cycle.
// Ports    : clk, rst (async, active-high)
//            start, op[1:0] (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//            rs_val, rt_val        operands from ID/EX
//            abort                 flush from a taken branch
//            busy, stall, done     status / pipeline hold / result pulse
//            hi, lo                product high/low or remainder/quotient
//            div0                  last divide had a zero divisor
// Config   : MULDIV_SIGNED_EN - when defined, op[0] selects signed MULT/DIV.
// Revision : 1.0 - initial release
// ============================================================================
module exe_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;   // {upper/remainder, lower/quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               divz_q, divz_d;   // divisor was zero, published at FIX
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;
  logic               qneg_q, qneg_d;   // product / quotient must be negated
  logic               rneg_q, rneg_d;   // remainder must be negated

  logic               w_is_div;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic               w_qneg;
  logic               w_rneg;
  logic [2*WIDTH-1:0] w_res;

  assign w_is_div = op[1];

`ifdef MULDIV_SIGNED_EN
  logic w_rs_neg;
  logic w_rt_neg;
  assign w_rs_neg = op[0] & rs_val[WIDTH-1];
  assign w_rt_neg = op[0] & rt_val[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_val : rs_val;
  assign w_rt_mag = w_rt_neg ? -rt_val : rt_val;
  assign w_qneg   = w_rs_neg ^ w_rt_neg;
  assign w_rneg   = w_rs_neg & w_is_div;

  // Product sign is qneg; for divides the halves are corrected separately
  // so the remainder follows the dividend and the quotient truncates to zero.
  always_comb begin
    w_res = work_q;
    if (is_div_q) begin
      w_res[WIDTH-1:0]       = qneg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
      w_res[2*WIDTH-1:WIDTH] = rneg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
    end else if (qneg_q) begin
      w_res = -work_q;
    end
  end
`else
  logic w_op0_unused;
  assign w_op0_unused = op[0];
  assign w_rs_mag     = rs_val;
  assign w_rt_mag     = rt_val;
  assign w_qneg       = 1'b0;
  assign w_rneg       = 1'b0;
  assign w_res        = work_q;
`endif

  // One multiply step: conditionally add, then shift the 65-bit sum right.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  // One restoring-divide step: shift in the next dividend bit, try subtract.
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;

  always_comb begin
    w_mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                + {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
    w_mul_next  = {w_mul_sum, work_q[WIDTH-1:1]};
    w_div_shift = work_q[2*WIDTH-1:WIDTH-1];
    w_div_diff  = w_div_shift - {1'b0, opnd_q};
    if (w_div_diff[WIDTH])
      w_div_next = {w_div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    else
      w_div_next = {w_div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    divz_d   = divz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div0_d   = div0_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q blocks re-execution of the instruction still held in ID/EX.
        if (start && !done_q && !abort) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          div0_d   = 1'b0;
          is_div_d = w_is_div;
          divz_d   = w_is_div && (rt_val == {WIDTH{1'b0}});
          opnd_d   = w_is_div ? w_rt_mag : w_rs_mag;
          work_d   = {{WIDTH{1'b0}}, (w_is_div ? w_rs_mag : w_rt_mag)};
          qneg_d   = w_qneg;
          rneg_d   = w_rneg;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          work_d = is_div_q ? w_div_next : w_mul_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST)
            state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          hi_d   = w_res[2*WIDTH-1:WIDTH];
          // Zero divisor: quotient is forced to all ones regardless of sign;
          // the remainder path already reproduces the dividend.
          lo_d   = divz_q ? {WIDTH{1'b1}} : w_res[WIDTH-1:0];
          div0_d = divz_q;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = (start & ~done_q) | busy;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign div0  = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_muldiv_unit
// Purpose  : Directed self-checking bench for exe_muldiv_unit. Expected values
//            are hand-computed; signed expectations follow MULDIV_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        abort;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  int n_chk;
  int n_pass;

  exe_muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .abort  (abort),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .div0   (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULDIV_SIGNED_EN
  localparam logic [31:0] C_MULT_HI = 32'hFFFF_FFFF;
  localparam logic [31:0] C_DIV7_LO = 32'hFFFF_FFFD;
  localparam logic [31:0] C_DIV7_HI = 32'hFFFF_FFFF;
  localparam logic [31:0] C_MIN_LO  = 32'h8000_0000;
  localparam logic [31:0] C_MIN_HI  = 32'h0000_0000;
`else
  localparam logic [31:0] C_MULT_HI = 32'h0000_0004;
  localparam logic [31:0] C_DIV7_LO = 32'h7FFF_FFFC;
  localparam logic [31:0] C_DIV7_HI = 32'h0000_0001;
  localparam logic [31:0] C_MIN_LO  = 32'h0000_0000;
  localparam logic [31:0] C_MIN_HI  = 32'h8000_0000;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Issues one operation with start held across the done cycle, then drops
  // start after E34 and checks latency, stall length and the result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_div0);
    int lat;
    int stl;
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    lat = -1; stl = 0;
    #1;
    if (stall) stl++;
    for (int e = 0; e < 100; e++) begin
      @(posedge clk); #1;
      if (e == 0) chk({tag, "_div0_e0"}, 64'(div0), 64'd0);
      if (done) begin
        lat = e;
        break;
      end
      if (stall) stl++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    chk({tag, "_stall_cycles"}, 64'(stl), 64'd34);
    chk({tag, "_stall_done"}, 64'(stall), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_div0"}, 64'(div0), 64'(exp_div0));
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_no_reexec"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    int seen;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div0", 64'(div0), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, C_MULT_HI, 32'hFFFF_FFF1, 1'b0);
    run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, C_DIV7_HI, C_DIV7_LO, 1'b0);
    run_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu_by0", 2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    run_op("multu_2x3", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    run_op("div_min", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, C_MIN_HI, C_MIN_LO, 1'b0);

    // Abort after E10: no done, HI/LO keep the previous result.
    @(negedge clk);
    op = 2'b00; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    abort = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    abort = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_hi", 64'(hi), 64'(C_MIN_HI));
    chk("abort_lo", 64'(lo), 64'(C_MIN_LO));

    // Asynchronous reset after E10 clears every output at once.
    @(negedge clk);
    op = 2'b00; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    #1;
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_div0", 64'(div0), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
